mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port between two requesters: the multicycle
//  core controller (port C) and the external program loader/debug master (port X). Issues exactly one
//  memory transaction at a time and returns a one-cycle response to its owner. Core has priority;
//  an anti-starvation counter forces port X through after MAX_WAIT denied cycles.
// PARAMETERS
//  ADDR_W    32  byte address width
//  DATA_W    32  data width; mask width is DATA_W/8
//  MEM_LAT   2   cycles from mem_en to valid mem_rdata (>=1)
//  MAX_WAIT  8   consecutive denied cycles for X before X wins over C (>=1)
// PORTS
//  clk        in   1         clock
//  rst        in   1         reset, asynchronous, active-high
//  c_req      in   1         core request; held with fields stable until c_gnt
//  c_we       in   1         core write (1) / read (0)
//  c_addr     in   ADDR_W    core address
//  c_wdata    in   DATA_W    core write data
//  c_wmask    in   DATA_W/8  core byte enables (writes only)
//  c_gnt      out  1         core request accepted this cycle
//  c_rvalid   out  1         core response pulse (reads and writes)
//  c_rdata    out  DATA_W    core read data, valid with c_rvalid
//  x_req, x_we, x_addr, x_wdata, x_wmask, x_gnt, x_rvalid, x_rdata  same as c_* for port X
//  mem_en     out  1         memory strobe, one cycle per transaction
//  mem_we     out  1         memory write
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_wmask  out  DATA_W/8  memory byte enables
//  mem_rdata  in   DATA_W    memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset: state IDLE, all gnt/rvalid/mem_en/mem_we 0, mem_addr/wdata/wmask/rdata outs 0, wait cnt 0.
//  States: IDLE, WAIT, RESP. Grant is allowed in IDLE and RESP only.
//  Grant cycle T: gnt pulses to winner, mem_en=1 and mem_* driven combinationally from winner's
//   fields; owner and we registered; lat_cnt loaded with MEM_LAT; state -> WAIT.
//  WAIT: lat_cnt decrements; when lat_cnt==1 at edge, mem_rdata captured into owner's rdata reg,
//   state -> RESP. Response pulse (owner rvalid=1) in cycle T+MEM_LAT+1, exactly one cycle.
//  RESP: no request -> IDLE; request -> new grant same cycle (back-to-back throughput
//   one transaction per MEM_LAT+1 cycles).
//  Writes: mem_rdata ignored, rdata holds previous value, rvalid still pulses (write ack).
//  Non-owner rvalid is 0; rdata regs hold last value until next owned response.
//  Arbitration when both request: C wins unless x_wait==MAX_WAIT, then X wins.
//  x_wait: +1 each cycle x_req=1 and x_gnt=0 (any state), saturates at MAX_WAIT; cleared on x_gnt
//   or when x_req=0.
//  mem_en=0 outside grant cycles; mem_* data outputs are don't-care when mem_en=0 but must be 0
//   in reset.
//  Reset mid-transaction: return to IDLE immediately, in-flight response discarded, no rvalid.
//  A requester dropping req before gnt is legal; no grant is issued for it.
// STRUCTURE
//  Package mem_arb_pkg: state enum (IDLE/WAIT/RESP), owner_t enum (OWN_C/OWN_X),
//   mem_req_t struct {we, addr, wdata, wmask}.
//  Sub-module mem_arb_pick: combinational winner selection from c_req, x_req, x_wait, MAX_WAIT;
//   outputs grant_c, grant_x. Counters, FSM and response regs stay in top level.
// TESTING
//  1 C read 0x100 alone, MEM_LAT=2, mem returns 0xDEADBEEF -> c_gnt at T, mem_en at T,
//    c_rvalid at T+3 with c_rdata=0xDEADBEEF, x_rvalid never.
//  2 C and X both request every cycle, MAX_WAIT=8 -> C granted until x_wait hits 8, next grant X,
//    then C again; X never starved.
//  3 X write 0x200 wdata 0x12345678 wmask 0b0011 -> mem_we=1, mem_wmask=0011, x_rvalid pulse
//    at T+3, x_rdata unchanged.
//  4 Back-to-back C reads held continuously -> grants at T, T+3, T+6; mem_en never two cycles
//    in a row.
//  5 rst asserted in WAIT -> outputs 0 asynchronously, no rvalid after release, next C req granted
//    first cycle.
//  6 MEM_LAT=1 run of scenario 1 -> c_rvalid at T+2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified memory port arbiter.
// Both requesters and the memory side use the same transaction fields.
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      OWN_C,
      OWN_X
   } owner_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
   } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core port, loader/debug port and memory port signals.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   logic              c_req;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic [MASK_W-1:0] c_wmask;
   logic              c_gnt;
   logic              c_rvalid;
   logic [DATA_W-1:0] c_rdata;

   logic              x_req;
   logic              x_we;
   logic [ADDR_W-1:0] x_addr;
   logic [DATA_W-1:0] x_wdata;
   logic [MASK_W-1:0] x_wmask;
   logic              x_gnt;
   logic              x_rvalid;
   logic [DATA_W-1:0] x_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [MASK_W-1:0] mem_wmask;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata, c_wmask,
      output c_gnt, c_rvalid, c_rdata,
      input  x_req, x_we, x_addr, x_wdata, x_wmask,
      output x_gnt, x_rvalid, x_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_rdata
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata, c_wmask,
      input  c_gnt, c_rvalid, c_rdata,
      output x_req, x_we, x_addr, x_wdata, x_wmask,
      input  x_gnt, x_rvalid, x_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_rdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: core has priority unless the loader has
// been denied MAX_WAIT consecutive cycles.
module mem_arb_pick #(
   parameter int MAX_WAIT = 8,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic             allow,
   input  logic             c_req,
   input  logic             x_req,
   input  logic [CNT_W-1:0] x_wait,
   output logic             grant_c,
   output logic             grant_x
);

   logic x_forced;

   always_comb begin
      x_forced = (x_wait == CNT_W'(MAX_WAIT));
      grant_c  = allow && c_req && !(x_req && x_forced);
      grant_x  = allow && x_req && (!c_req || x_forced);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core (C) and the loader/debug master (X),
// one transaction in flight at a time, with a one-cycle response to the owner.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 8
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam int LAT_W = $clog2(MEM_LAT + 1);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   state_t            state;
   state_t            state_nx;
   owner_t            owner;
   logic              owner_we;
   logic [LAT_W-1:0]  lat_cnt;
   logic [CNT_W-1:0]  x_wait;
   logic [DATA_W-1:0] c_rdata_q;
   logic [DATA_W-1:0] x_rdata_q;

   logic              allow;
   logic              grant_c;
   logic              grant_x;
   logic              grant;
   mem_req_t          c_fields;
   mem_req_t          x_fields;
   mem_req_t          win;

   // New transactions start only when nothing is in flight; the response
   // cycle counts as free so back-to-back requests lose no cycle.
   assign allow = !rst && (state == IDLE || state == RESP);
   assign grant = grant_c || grant_x;

   mem_arb_pick #(
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) u_pick (
      .allow   (allow),
      .c_req   (bus.c_req),
      .x_req   (bus.x_req),
      .x_wait  (x_wait),
      .grant_c (grant_c),
      .grant_x (grant_x)
   );

   always_comb begin
      c_fields = '{we: bus.c_we, addr: bus.c_addr, wdata: bus.c_wdata, wmask: bus.c_wmask};
      x_fields = '{we: bus.x_we, addr: bus.x_addr, wdata: bus.x_wdata, wmask: bus.x_wmask};
      win      = '0;
      if (grant_c) begin
         win = c_fields;
      end else if (grant_x) begin
         win = x_fields;
      end
   end

   assign bus.mem_en    = grant;
   assign bus.mem_we    = win.we;
   assign bus.mem_addr  = win.addr;
   assign bus.mem_wdata = win.wdata;
   assign bus.mem_wmask = win.wmask;

   assign bus.c_gnt     = grant_c;
   assign bus.x_gnt     = grant_x;
   assign bus.c_rvalid  = (state == RESP) && (owner == OWN_C);
   assign bus.x_rvalid  = (state == RESP) && (owner == OWN_X);
   assign bus.c_rdata   = c_rdata_q;
   assign bus.x_rdata   = x_rdata_q;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant) state_nx = WAIT;
         WAIT:    if (lat_cnt == LAT_W'(1)) state_nx = RESP;
         RESP:    state_nx = grant ? WAIT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Owner and direction are latched at grant; read data is captured on the
   // last latency cycle, writes leave the owner's rdata untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner     <= OWN_C;
         owner_we  <= 1'b0;
         lat_cnt   <= '0;
         c_rdata_q <= '0;
         x_rdata_q <= '0;
      end else if (grant) begin
         owner    <= grant_x ? OWN_X : OWN_C;
         owner_we <= win.we;
         lat_cnt  <= LAT_W'(MEM_LAT);
      end else if (state == WAIT) begin
         lat_cnt <= lat_cnt - LAT_W'(1);
         if (lat_cnt == LAT_W'(1) && !owner_we) begin
            if (owner == OWN_X) begin
               x_rdata_q <= bus.mem_rdata;
            end else begin
               c_rdata_q <= bus.mem_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_wait <= '0;
      end else if (bus.x_req && !grant_x) begin
         if (x_wait != CNT_W'(MAX_WAIT)) begin
            x_wait <= x_wait + CNT_W'(1);
         end
      end else begin
         x_wait <= '0;
      end
   end

endmodule
